// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data-memory arbiter and its round-robin core.
package data_mem_pkg;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 255;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with owner lock; purely combinational, one-hot or zero grant.
module rr_arb2
   import data_mem_pkg::*;
(
   input  logic [1:0] req,
   input  port_t      last_owner,
   input  logic       lock_held,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (lock_held && req[last_owner]) begin
         gnt[last_owner] = 1'b1;
      end else if (req == 2'b11) begin
         // on a tie the port that did not own the last access goes next
         gnt = (last_owner == PORT1) ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the load/store stage (port 0) and a
// secondary master (port 1); one access per cycle, read data returned one cycle later.
module data_mem_arbiter #(
   parameter int ADDR_W    = data_mem_pkg::ADDR_W,
   parameter int DATA_W    = data_mem_pkg::DATA_W,
   parameter int MEM_DEPTH = data_mem_pkg::MEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [1:0]        lock,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import data_mem_pkg::*;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

   port_t             last_owner;
   logic              lock_held;
   logic [1:0]        arb_gnt;
   port_t             winner;
   logic              any_gnt;
   logic              sel_we;
   logic              in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic [1:0]        rvalid_p1;
   logic [1:0]        err_p1;
   logic [DATA_W-1:0] rdata_p1;

   rr_arb2 u_arb (
      .req        (req),
      .last_owner (last_owner),
      .lock_held  (lock_held),
      .gnt        (arb_gnt)
   );

   // stage 0: grant, request mux and range check
   always_comb begin
      gnt       = reset ? 2'b00 : arb_gnt;
      any_gnt   = |gnt;
      winner    = gnt[1] ? PORT1 : PORT0;
      sel_addr  = (winner == PORT1) ? addr1 : addr0;
      sel_wdata = (winner == PORT1) ? wdata1 : wdata0;
      sel_we    = we[winner];
      in_range  = {1'b0, sel_addr} < DEPTH_L;
      // out-of-range accesses are granted but never reach the memory
      mem_read  = any_gnt & ~sel_we & in_range;
      mem_write = any_gnt & sel_we & in_range;
      mem_addr  = any_gnt ? sel_addr : '0;
      mem_wdata = any_gnt ? sel_wdata : '0;
   end

   // stage 1: owner/lock state and read-return registers
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner <= PORT1;
         lock_held  <= 1'b0;
         rvalid_p1  <= 2'b00;
         err_p1     <= 2'b00;
         rdata_p1   <= '0;
      end else begin
         rvalid_p1 <= 2'b00;
         err_p1    <= 2'b00;
         if (any_gnt) begin
            last_owner <= winner;
            lock_held  <= lock[winner];
            if (!sel_we) begin
               rvalid_p1[winner] <= 1'b1;
               rdata_p1          <= in_range ? mem_rdata : '0;
            end
            if (!in_range) err_p1[winner] <= 1'b1;
         end else begin
            lock_held <= 1'b0;
         end
      end
   end

   assign rvalid = rvalid_p1;
   assign err    = err_p1;
   assign rdata  = rdata_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: reference model of arbitration and memory contents checked
// every cycle, plus hand-computed pinned values from directed scenarios.
module tb_data_mem_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req = 2'b11, we = 2'b00, lock = 2'b00;
   logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
   logic [1:0] gnt, rvalid, err;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic       mem_read, mem_write;

   logic [7:0] env_mem [256];
   logic [7:0] ref_mem [256];

   int n_cmp = 0;
   int n_bad = 0;

   int pin_gnt = -1, pin_mw = -1, pin_rv = -1, pin_err = -1, pin_rd = -1;

   int         m_owner = 1;
   bit         m_locked = 1'b0;
   logic [1:0] m_rvalid = 2'b00, m_err = 2'b00;
   logic [7:0] m_rdata = 8'h00;

   data_mem_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // the data memory itself: combinational read, write at the clock edge
   assign mem_rdata = env_mem[mem_addr];
   always @(posedge clk) if (mem_write) env_mem[mem_addr] <= mem_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      int         w;
      bit         g;
      bit         inr;
      logic [7:0] a;
      logic [7:0] d;
      logic [1:0] eg;
      w = 0;
      g = 1'b0;
      if (!reset && req != 2'b00) begin
         g = 1'b1;
         if (m_locked && req[m_owner]) w = m_owner;
         else if (req == 2'b11) w = 1 - m_owner;
         else w = req[1] ? 1 : 0;
      end
      a   = (w == 1) ? addr1 : addr0;
      d   = (w == 1) ? wdata1 : wdata0;
      inr = (a < 8'd255);
      eg  = g ? 2'(1 << w) : 2'b00;

      chk("gnt", 32'(gnt), 32'(eg));
      chk("mem_read", 32'(mem_read), 32'(g && !we[w] && inr));
      chk("mem_write", 32'(mem_write), 32'(g && we[w] && inr));
      chk("mem_addr", 32'(mem_addr), g ? 32'(a) : 32'd0);
      chk("mem_wdata", 32'(mem_wdata), g ? 32'(d) : 32'd0);
      chk("rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("err", 32'(err), 32'(m_err));
      chk("rdata", 32'(rdata), 32'(m_rdata));

      if (pin_gnt >= 0) chk("pin_gnt", 32'(gnt), pin_gnt);
      if (pin_mw  >= 0) chk("pin_mem_write", 32'(mem_write), pin_mw);
      if (pin_rv  >= 0) chk("pin_rvalid", 32'(rvalid), pin_rv);
      if (pin_err >= 0) chk("pin_err", 32'(err), pin_err);
      if (pin_rd  >= 0) chk("pin_rdata", 32'(rdata), pin_rd);

      if (reset) begin
         m_owner  = 1;
         m_locked = 1'b0;
         m_rvalid = 2'b00;
         m_err    = 2'b00;
         m_rdata  = 8'h00;
      end else begin
         m_rvalid = 2'b00;
         m_err    = 2'b00;
         if (g) begin
            m_owner  = w;
            m_locked = lock[w];
            if (!we[w]) begin
               m_rvalid[w] = 1'b1;
               m_rdata     = inr ? ref_mem[a] : 8'h00;
            end
            if (!inr) m_err[w] = 1'b1;
            else if (we[w]) ref_mem[a] = d;
         end else begin
            m_locked = 1'b0;
         end
      end
   end

   task automatic cyc(input logic rst, input logic [1:0] rq, input logic [1:0] w,
                      input logic [1:0] lk, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input int pg = -1, input int pmw = -1, input int prv = -1,
                      input int perr = -1, input int prd = -1);
      @(posedge clk);
      #1;
      reset = rst; req = rq; we = w; lock = lk;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      pin_gnt = pg; pin_mw = pmw; pin_rv = prv; pin_err = perr; pin_rd = prd;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 8'(i) ^ 8'hA5;
         ref_mem[i] = 8'(i) ^ 8'hA5;
      end

      // reset with both ports requesting
      cyc(1, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
      cyc(1, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 8'h00, 8'h00, 1);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 1, 0, 8'h85);

      // write then read-after-write from the other port
      cyc(0, 2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 8'h5A, 8'h00, 1, 1);
      cyc(0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00, 2, 0);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 2, 0, 8'h5A);

      // sustained tie alternates
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 1);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2, -1, 1, -1, 8'hA4);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 1, -1, 2, -1, 8'hA7);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2);

      // lock: port 1 holds three reads against a pending port 0
      cyc(0, 2'b01, 2'b00, 2'b00, 8'h03, 8'h00, 8'h00, 8'h00, 1);
      cyc(0, 2'b11, 2'b00, 2'b10, 8'h04, 8'h30, 8'h00, 8'h00, 2);
      cyc(0, 2'b11, 2'b00, 2'b10, 8'h04, 8'h31, 8'h00, 8'h00, 2);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h04, 8'h32, 8'h00, 8'h00, 2);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h04, 8'h33, 8'h00, 8'h00, 1);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

      // out-of-range boundary
      cyc(0, 2'b01, 2'b01, 2'b00, 8'hFF, 8'h00, 8'h77, 8'h00, 1, 0);
      cyc(0, 2'b01, 2'b00, 2'b00, 8'hFE, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 1, 0, 8'h5B);
      cyc(0, 2'b10, 2'b00, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 2, 0);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 2, 2, 8'h00);

      // reset in the middle of a locked sequence and a pending port 1 read
      cyc(0, 2'b01, 2'b00, 2'b01, 8'h06, 8'h00, 8'h00, 8'h00, 1);
      cyc(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h07, 8'h05, 8'h00, 8'h00, 1, -1, 0, 0);
      cyc(0, 2'b11, 2'b00, 2'b00, 8'h07, 8'h05, 8'h00, 8'h00, 2, -1, 1);

      // mixed traffic over a small address window and the top boundary
      for (int i = 0; i < 80; i++) begin
         logic [7:0] ra0, ra1;
         ra0 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(250, 255));
         ra1 = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(250, 255));
         cyc(0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             ra0, ra1, 8'($urandom), 8'($urandom));
      end
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      cyc(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 0, 0);

      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-ported 8-bit data memory between the core load/store stage (port 0) and a secondary master such as a loader or copy engine (port 1). It issues at most one memory access per cycle. Grants are round-robin, with an optional lock for back-to-back sequences such as read-modify-write. Read data is registered and returned one cycle after the grant. It sits directly between the masters and the data memory's memRead/memWrite/dataAddr/writeData/readDataOut pins.

## Interface
Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_DEPTH, 255, valid entries; addresses ≥ MEM_DEPTH are out of range.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req[1:0]  in  2  access request per port.
- we[1:0]  in  2  per port: 1 = write, 0 = read.
- lock[1:0]  in  2  owner keeps the grant on its next request.
- addr0, addr1  in  ADDR_W  per-port address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- gnt[1:0]  out  2  combinational, one-hot or zero; access performed this cycle.
- rvalid[1:0]  out  2  registered; read data valid for that port.
- rdata  out  DATA_W  registered read data, shared by both ports.
- err[1:0]  out  2  registered; out-of-range access completed.
- mem_read, mem_write  out  1  memory strobes.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational memory read data.

## Operation
- Requester protocol:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - The access completes in the gnt cycle.
  - The requester may drop req or present a new request in the next cycle.
- Arbitration, evaluated combinationally each cycle:
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not last_owner wins.
- Lock:
  - Condition: lock_held = 1 and last_owner requests.
  - Effect: last_owner wins regardless of the other port.
  - lock_held is set on a grant with lock[owner] = 1.
  - lock_held clears on a grant with lock = 0, or on a cycle where the owner does not request.
- On each edge with a grant: last_owner ← the winning port.
- Memory drive:
  - The winner's addr and wdata are muxed onto mem_addr and mem_wdata.
  - mem_read = grant & ~we; mem_write = grant & we.
  - With no grant: strobes are 0, mem_addr = 0, mem_wdata = 0.
- Out of range (addr ≥ MEM_DEPTH):
  - The grant is still issued.
  - Both mem strobes are suppressed.
  - err[winner] pulses next cycle.
  - For a read, rvalid[winner] also pulses with rdata = 0.
- Read return: the edge ending the grant cycle captures mem_rdata into rdata and sets rvalid[winner].
- Output hold:
  - rvalid deasserts the following cycle unless another read is granted.
  - rdata holds its last value otherwise.
- States: IDLE/OWN0/OWN1 are encoded by last_owner and lock_held. No other FSM states.

## Timing
- Reset values:
  - rvalid = 00, err = 00, rdata = 0.
  - last_owner = 1, so port 0 wins the first tie.
  - lock_held = 0.
  - gnt = 00 and all strobes 0 while reset is high, regardless of req.
- Reset asserted mid-operation:
  - Any access presented in that cycle is not granted and has no memory effect.
  - The requester must re-present after reset.
- Latency:
  - gnt arrives in the same cycle as the request (0 cycles) when uncontended.
  - A write commits at the edge ending the gnt cycle.
  - Read data is valid in cycle N+1 for a grant in cycle N.
- Throughput: one access per cycle. Alternating ties give each port 1 access per 2 cycles.
- Starvation bound:
  - Without lock, a pending request is granted within 2 cycles.
  - With lock, within 1 cycle after the owner drops lock or req.
- Read-after-write to the same address from either port in consecutive cycles returns the new data.

## Structure
- Package data_mem_pkg holds:
  - ADDR_W, DATA_W and MEM_DEPTH constants.
  - typedef logic [ADDR_W-1:0] addr_t and logic [DATA_W-1:0] data_t.
  - typedef enum logic {PORT0, PORT1} port_t, used for last_owner.
- Sub-module rr_arb2 takes req, last_owner and lock_held and returns a one-hot grant; it is purely combinational.
- The top level holds the owner/lock registers, the request mux, the range check and the read-return registers.

## Test plan
- Reset held 2 cycles with req = 11 → gnt = 00, no strobes. After release, rvalid = 00 and rdata = 0; the first tie grants port 0.
- Port 0 writes 0x5A to 0x10 in cycle N; port 1 reads 0x10 in cycle N+1 → rvalid[1] in N+2 with rdata = 0x5A.
- req = 11 held for 4 cycles, no lock → gnt sequence 01, 10, 01, 10.
- Port 1 asserts lock for 3 consecutive reads with port 0 requesting throughout → gnt = 10, 10, 10. Port 1 then drops lock → port 0 is granted the next cycle.
- Port 0 writes to 0xFF → gnt = 01, mem_write = 0, err[0] pulses next cycle. Port 0 reads 0xFE → valid, no err.
- Reset asserted during a granted port 1 read → no rvalid the next cycle; last_owner = 1, lock_held = 0.
